// File: rtl/axi_sram_rd_slave.sv
// AXI4 read-channel responder backed by a synchronous single-port SRAM.
// Handles one AR request at a time and supports FIXED, INCR and WRAP bursts of
// up to 256 beats on a 64-bit data path. Each beat costs one SRAM read and is
// held on R until the master accepts it.
module axi_sram_rd_slave #(
    parameter logic [31:0] MEM_BASE = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0800_0000
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        arready,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [63:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    logic [31:0] addr_reg;
    logic [3:0]  id_reg;
    logic [7:0]  len_reg;
    logic [2:0]  size_reg;
    logic [1:0]  burst_reg;
    logic [7:0]  beat_cnt_reg;
    logic        burst_err_reg;
    logic [63:0] rdata_reg;
    logic [1:0]  rresp_reg;
    logic        rlast_reg;

    logic        ar_hs;
    logic        r_hs;
    logic        ar_err;
    logic [31:0] ar_incr;
    logic        wrap_len_ok;
    logic [31:0] beat_incr;
    logic [31:0] wrap_mask;
    logic [31:0] addr_sum;
    logic [31:0] addr_adv;
    logic [31:0] range_off;
    logic        beat_decerr;
    logic        beat_err;

    // Handshakes; arready drops as soon as rst goes low, without waiting for a clock
    assign arready = (state_reg == IDLE) & rst;
    assign ar_hs   = arvalid & arready;
    assign r_hs    = (state_reg == RESP) & rready;

    // Burst-level legality of the incoming request, latched at AR acceptance
    always_comb begin
        ar_incr     = 32'd1 << arsize;
        wrap_len_ok = (arlen == 8'd1) | (arlen == 8'd3) | (arlen == 8'd7) | (arlen == 8'd15);
        ar_err      = 1'b0;
        if (arburst == BURST_RSVD)
            ar_err = 1'b1;
        if (arsize > 3'd3)
            ar_err = 1'b1;
        if ((arburst == BURST_WRAP) && !wrap_len_ok)
            ar_err = 1'b1;
        if ((arburst == BURST_WRAP) && ((araddr & (ar_incr - 32'd1)) != 32'd0))
            ar_err = 1'b1;
    end

    // Next-beat address: WRAP keeps the upper bits of the wrap window and
    // lets only the in-window offset roll over
    always_comb begin
        beat_incr = 32'd1 << size_reg;
        wrap_mask = (({24'd0, len_reg} + 32'd1) << size_reg) - 32'd1;
        addr_sum  = addr_reg + beat_incr;
        unique case (burst_reg)
            BURST_FIXED: addr_adv = addr_reg;
            BURST_WRAP:  addr_adv = (addr_reg & ~wrap_mask) | (addr_sum & wrap_mask);
            default:     addr_adv = addr_sum;
        endcase
    end

    // Per-beat decode: the unsigned offset from MEM_BASE wraps high for
    // addresses below the window, so one compare covers both edges
    always_comb begin
        range_off   = addr_reg - MEM_BASE;
        beat_decerr = (range_off >= MEM_SIZE);
        beat_err    = burst_err_reg | beat_decerr;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: one SRAM read, one capture, then hold until accepted
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (ar_hs) state_next = REQ;
            REQ:     state_next = CAPT;
            CAPT:    state_next = RESP;
            RESP:    if (r_hs) state_next = rlast_reg ? IDLE : REQ;
            default: state_next = IDLE;
        endcase
    end

    // Burst context: latched on AR, advanced after every non-final beat is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg      <= 32'd0;
            id_reg        <= 4'd0;
            len_reg       <= 8'd0;
            size_reg      <= 3'd0;
            burst_reg     <= BURST_FIXED;
            beat_cnt_reg  <= 8'd0;
            burst_err_reg <= 1'b0;
        end else if (ar_hs) begin
            addr_reg      <= araddr;
            id_reg        <= arid;
            len_reg       <= arlen;
            size_reg      <= arsize;
            burst_reg     <= arburst;
            beat_cnt_reg  <= 8'd0;
            burst_err_reg <= ar_err;
        end else if (r_hs && !rlast_reg) begin
            addr_reg      <= addr_adv;
            beat_cnt_reg  <= beat_cnt_reg + 8'd1;
        end
    end

    // R beat holding registers, loaded once per beat so they stay stable under stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= 64'd0;
            rresp_reg <= RESP_OKAY;
            rlast_reg <= 1'b0;
        end else if (state_reg == CAPT) begin
            rdata_reg <= beat_err ? 64'd0 : mem_rdata;
            rresp_reg <= burst_err_reg ? RESP_SLVERR : (beat_decerr ? RESP_DECERR : RESP_OKAY);
            rlast_reg <= (beat_cnt_reg == len_reg);
        end
    end

    // SRAM read strobe is suppressed for any beat that will not return data
    assign mem_ren   = (state_reg == REQ) & ~beat_err;
    assign mem_raddr = (state_reg == REQ) ? {addr_reg[31:3], 3'b000} : 32'd0;

    assign rvalid = (state_reg == RESP);
    assign rdata  = rdata_reg;
    assign rresp  = rresp_reg;
    assign rlast  = rlast_reg;
    assign rid    = id_reg;

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Self-checking bench for axi_sram_rd_slave: directed scenarios plus random
// bursts compared against a closed-form burst model and a hashed SRAM image.
module tb_axi_sram_rd_slave;

    localparam logic [31:0] MEM_BASE = 32'h8000_0000;
    localparam logic [31:0] MEM_SIZE = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arvalid = 1'b0;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arready;
    logic        rready = 1'b0;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        rlast;
    logic [3:0]  rid;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [63:0] mem_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] ren_log[$];

    axi_sram_rd_slave #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arready(arready),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
        .rlast(rlast), .rid(rid),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM image: one fixed word for the directed test, a hash elsewhere
    function automatic logic [63:0] sram_word(input logic [31:0] a);
        if (a == 32'h8000_0010)
            return 64'hDEAD_BEEF_0123_4567;
        return {a ^ 32'h5A5A_1234, ~a};
    endfunction

    // Synchronous SRAM model; every strobe is logged for address checks
    always @(posedge clk) begin
        if (mem_ren) begin
            ren_log.push_back(mem_raddr);
            mem_rdata <= sram_word(mem_raddr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Address of beat i, computed directly from the start address
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                              input logic [2:0] sz, input logic [1:0] bt,
                                              input logic [7:0] len);
        longint unsigned au    = 64'(a);
        longint unsigned incr  = 64'd1 << sz;
        longint unsigned wsize = (64'(len) + 64'd1) * incr;
        longint unsigned lo;
        if (bt == 2'b00)
            return a;
        if (bt == 2'b10) begin
            lo = au - (au % wsize);
            return 32'(lo + ((au - lo + 64'(i) * incr) % wsize));
        end
        return 32'(au + 64'(i) * incr);
    endfunction

    function automatic bit burst_err(input logic [31:0] a, input logic [7:0] len,
                                     input logic [2:0] sz, input logic [1:0] bt);
        if (bt == 2'b11 || sz > 3'd3)
            return 1'b1;
        if (bt == 2'b10) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
                return 1'b1;
            if ((64'(a) % (64'd1 << sz)) != 64'd0)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] exp_resp(input bit berr, input logic [31:0] ba);
        if (berr)
            return 2'b10;
        if (64'(ba) < 64'(MEM_BASE) || 64'(ba) >= 64'(MEM_BASE) + 64'(MEM_SIZE))
            return 2'b11;
        return 2'b00;
    endfunction

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        int t = 0;
        @(negedge clk);
        arvalid = 1'b1; arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt;
        while (!arready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!arready)
            chk("ar_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic take_beat(input logic [63:0] edata, input logic [1:0] eresp,
                             input logic elast, input logic [3:0] eid,
                             input int stall, input bit first);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rvalid && w < 100);
        if (!rvalid) begin
            chk("r_timeout", 64'd0, 64'd1);
            return;
        end
        if (first)
            chk("r_latency", 64'(w), 64'd3);
        else
            chk("r_spacing", 64'(w >= 3), 64'd1);
        chk("rdata", rdata, edata);
        chk("rresp", 64'(rresp), 64'(eresp));
        chk("rlast", 64'(rlast), 64'(elast));
        chk("rid", 64'(rid), 64'(eid));
        chk("arready_busy", 64'(arready), 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_rvalid", 64'(rvalid), 64'd1);
            chk("stall_rdata", rdata, edata);
            chk("stall_rresp", 64'(rresp), 64'(eresp));
            chk("stall_rlast", 64'(rlast), 64'(elast));
        end
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bt,
                             input int stall_beat, input int stall_n);
        logic [31:0] exp_addrs[$];
        bit          berr = burst_err(a, len, sz, bt);
        logic [31:0] ba;
        logic [1:0]  rs;
        logic [63:0] d;
        ren_log.delete();
        send_ar(id, a, len, sz, bt);
        for (int i = 0; i <= int'(len); i++) begin
            ba = beat_addr(a, i, sz, bt, len);
            rs = exp_resp(berr, ba);
            d  = (rs == 2'b00) ? sram_word({ba[31:3], 3'b000}) : 64'd0;
            if (rs == 2'b00)
                exp_addrs.push_back({ba[31:3], 3'b000});
            take_beat(d, rs, (i == int'(len)), id, (i == stall_beat) ? stall_n : 0, (i == 0));
        end
        @(negedge clk);
        chk("arready_idle", 64'(arready), 64'd1);
        chk("ren_count", 64'(ren_log.size()), 64'(exp_addrs.size()));
        for (int k = 0; k < exp_addrs.size() && k < ren_log.size(); k++)
            chk("ren_addr", 64'(ren_log[k]), 64'(exp_addrs[k]));
        $display("burst id=%0d addr=%h len=%0d size=%0d burst=%0d done", id, a, len, sz, bt);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bt;
        int          sel;

        // Reset state
        #12;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_mem_ren", 64'(mem_ren), 64'd0);
        chk("rst_mem_raddr", 64'(mem_raddr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_arready", 64'(arready), 64'd1);

        // Directed scenarios
        run_burst(4'd1, 32'h8000_0010, 8'd0, 3'd3, 2'b01, -1, 0);
        run_burst(4'd5, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 1, 5);
        run_burst(4'd6, 32'h8000_0030, 8'd3, 3'd3, 2'b10, -1, 0);
        run_burst(4'd7, 32'h8000_0040, 8'd2, 3'd3, 2'b11, -1, 0);
        run_burst(4'd8, MEM_BASE + MEM_SIZE - 32'd8, 8'd1, 3'd3, 2'b01, -1, 0);

        // Asynchronous reset while beat 2 of 4 is being presented
        send_ar(4'd3, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
        take_beat(sram_word(32'h8000_0100), 2'b00, 1'b0, 4'd3, 0, 1'b1);
        begin
            int w = 0;
            while (!rvalid && w < 100) begin
                @(negedge clk);
                w++;
            end
        end
        chk("prerst_rvalid", 64'(rvalid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(rvalid), 64'd0);
        chk("midrst_arready", 64'(arready), 64'd0);
        chk("midrst_rdata", rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("postrst_arready", 64'(arready), 64'd1);
        chk("postrst_rvalid", 64'(rvalid), 64'd0);
        run_burst(4'd9, 32'h8000_0010, 8'd0, 3'd3, 2'b01, -1, 0);

        // Second request held on AR while the first burst is in flight
        ren_log.delete();
        send_ar(4'd1, 32'h8000_0200, 8'd1, 3'd3, 2'b01);
        arvalid = 1'b1; arid = 4'd2; araddr = 32'h8000_0300; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
        take_beat(sram_word(32'h8000_0200), 2'b00, 1'b0, 4'd1, 0, 1'b1);
        take_beat(sram_word(32'h8000_0208), 2'b00, 1'b1, 4'd1, 0, 1'b0);
        @(negedge clk);
        chk("b2b_arready", 64'(arready), 64'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        take_beat(sram_word(32'h8000_0300), 2'b00, 1'b1, 4'd2, 0, 1'b1);
        chk("b2b_ren_count", 64'(ren_log.size()), 64'd3);

        // Random bursts
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            bt  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            sz  = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            if (bt == 2'b10) begin
                case ($urandom_range(0, 4))
                    0: len = 8'd1;
                    1: len = 8'd3;
                    2: len = 8'd7;
                    3: len = 8'd15;
                    default: len = 8'd2;
                endcase
            end else begin
                len = 8'($urandom_range(0, 7));
            end
            if (sel < 7)
                a = MEM_BASE + 32'($urandom_range(0, 4095));
            else if (sel < 9)
                a = MEM_BASE + MEM_SIZE - 32'($urandom_range(1, 64));
            else
                a = MEM_BASE - 32'($urandom_range(1, 64));
            if (bt == 2'b10 && $urandom_range(0, 3) != 0)
                a = a & ~((32'd1 << sz) - 32'd1);
            run_burst(4'($urandom_range(0, 15)), a, len, sz, bt,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_sram_rd_slave.md
Name: axi_sram_rd_slave

Overview:
- AXI4 read-channel responder that sits downstream of the IF/MEM read crossbar and answers its AR/R traffic from a synchronous single-port SRAM.
- Accepts one AR request at a time and supports FIXED, INCR and WRAP bursts of up to 256 beats, with a 64-bit data path.
- Issues one SRAM read per beat and returns the beat on R with full valid/ready back-pressure.
- Echoes ID and generates RLAST and RRESP per beat.

Parameters:
- MEM_BASE, 32'h8000_0000, lowest byte address served.
- MEM_SIZE, 32'h0800_0000, bytes served; beat addresses outside [MEM_BASE, MEM_BASE+MEM_SIZE) return DECERR.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- arvalid in 1: AR request valid.
- araddr in 32: start byte address.
- arid in 4: transaction ID.
- arlen in 8: beats-1.
- arsize in 3: log2 bytes per beat.
- arburst in 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- arready out 1: AR accept.
- rready in 1: master accepts beat.
- rvalid out 1: beat valid.
- rresp out 2: 00 OKAY, 10 SLVERR, 11 DECERR.
- rdata out 64: beat data.
- rlast out 1: final beat.
- rid out 4: echoed arid.
- mem_ren out 1: SRAM read strobe, one cycle.
- mem_raddr out 32: SRAM byte address, bits[2:0] forced 0.
- mem_rdata in 64: SRAM data, valid the cycle after mem_ren.

Behaviour:
- Reset (rst=0, async): state IDLE; arready=0, rvalid=0, rresp=0, rdata=0, rlast=0, rid=0, mem_ren=0, mem_raddr=0. Any in-flight burst is dropped with no further beats.
- arready = (state==IDLE) & rst. This is combinational; arready=1 in IDLE after reset.
- States:
  - IDLE: on arvalid&arready, latch araddr/arid/arlen/arsize/arburst, clear beat_cnt, evaluate burst error, go to REQ.
  - REQ: mem_ren=1 and mem_raddr={addr[31:3],3'b0}, unless the beat is an error, in which case mem_ren=0. Go to CAPT.
  - CAPT: rdata_q <= (beat error ? 0 : mem_rdata); rresp_q set; rlast_q <= (beat_cnt==arlen_q). Go to RESP.
  - RESP: rvalid=1 with rdata/rresp/rlast/rid held stable until rready.
    - On rready with rlast: go to IDLE.
    - On rready without rlast: beat_cnt+1, advance addr, go to REQ.
- Latency: handshake at edge N; first rvalid=1 from edge N+3. Beats follow at a minimum spacing of 3 cycles. arready deasserts the cycle after the AR handshake.
- Address advance uses incr = 1<<arsize:
  - FIXED: addr unchanged.
  - INCR: addr + incr, 32-bit wrap.
  - WRAP: wsize = (arlen+1)<<arsize; next = (addr & ~(wsize-1)) | ((addr+incr) & (wsize-1)).
- Burst error, SLVERR on every beat: arburst==11; arsize>3; WRAP with arlen not in {1,3,7,15}; WRAP with araddr not aligned to incr. Full arlen+1 beats are still returned, with rdata=0.
- Per-beat DECERR: addr outside the MEM range and no burst error. mem_ren is suppressed and rdata=0.
- Priority per beat: SLVERR > DECERR > OKAY.
- rid equals the latched arid for all beats. rlast=1 only on beat arlen.
- rvalid never drops before rready. Once rvalid is asserted, outputs must not change while rready=0.
- arvalid while busy is ignored, since arready=0. The request waits in the master.
- rready=1 outside RESP has no effect.

Test Plan:
- Single beat: araddr=0x8000_0010, arid=1, arlen=0, arsize=3, INCR, SRAM[0x10]=0xDEAD_BEEF_0123_4567 -> mem_ren one cycle at addr 0x8000_0010. rvalid at handshake+3 with that data, rresp=00, rlast=1, rid=1. arready returns 1 the next cycle.
- INCR 4×8B from 0x8000_0000, rready held 0 for 5 cycles on beat 2 -> mem_raddr sequence 0x..00, 08, 10, 18. Beat-2 outputs stay stable while stalled; rlast only on beat 4.
- WRAP arlen=3, arsize=3, araddr=0x8000_0030 -> addresses 0x30, 0x38, 0x20, 0x28. All rresp=00.
- Errors: arburst=11, arlen=2 -> 3 beats with rresp=10, rdata=0, no mem_ren. INCR from MEM_BASE+MEM_SIZE-8, arlen=1 -> beat 1 OKAY, beat 2 rresp=11 with no mem_ren.
- Reset mid-burst: rst=0 asynchronously during RESP of beat 2 of 4 -> rvalid=0 and arready=0 immediately. After release, IDLE with arready=1, and a new single-beat read completes normally.
- Back-to-back: arvalid held high with a second request (arid=2) during a first burst (arid=1) -> the second is accepted only in the cycle after the first rlast handshake, and each beat carries its own rid.
